axi4_burst_master: RTL and testbench

AXI4_BURST_MASTER -- requirements
Module: axi4_burst_master

---
 rtl/axi4_burst_master.sv | 248 ++++++++++++++++++++++++
 tb/tb_axi4_burst_master.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_master.sv
// -----------------------------------------------------------------------------
// axi4_burst_master
//
// Turns a simple command interface into one AXI4 INCR-style burst per command:
// a write command drives AW, W and B; a read command drives AR and R. Write
// beats are passed straight through from a local valid/ready source, and read
// beats are forwarded to a strobe-only sink. Every command ends with a
// one-cycle done pulse. err is pulsed together with done when the command
// failed.
//
// Optional feature (compile-time macro AXI_4K_CHECK_EN):
//   When defined, a command whose burst would cross a 4 KiB boundary is
//   rejected at acceptance. No AXI traffic is generated for it, and done+err
//   pulse on the next cycle. When the macro is undefined, every command is
//   issued unchecked.
//
// Parameters
//   ADDR_W     AXI address width (>= 12)
//   DATA_W     AXI data width (8..1024, power of two)
//
// Ports
//   ACLK, ARESETn                  clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_write, cmd_addr, cmd_len   direction, start byte address, beats-1
//   wr_data/wr_valid/wr_ready      write beat source
//   rd_data/rd_valid               read beat sink (no backpressure)
//   done, err                      completion pulse, failure pulse
//   AW*, W*, B*, AR*, R*           AXI4 master channels (subset)
// -----------------------------------------------------------------------------
module axi4_burst_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESETn,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_len,

    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,

    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,

    output logic              done,
    output logic              err,

    output logic [ADDR_W-1:0] AWADDR,
    output logic [7:0]        AWLEN,
    output logic              AWVALID,
    input  logic              AWREADY,

    output logic [DATA_W-1:0] WDATA,
    output logic              WLAST,
    output logic              WVALID,
    input  logic              WREADY,

    input  logic              BVALID,
    output logic              BREADY,

    output logic [ADDR_W-1:0] ARADDR,
    output logic [7:0]        ARLEN,
    output logic              ARVALID,
    input  logic              ARREADY,

    input  logic [DATA_W-1:0] RDATA,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AW   = 3'd1;
    localparam logic [2:0] S_W    = 3'd2;
    localparam logic [2:0] S_B    = 3'd3;
    localparam logic [2:0] S_AR   = 3'd4;
    localparam logic [2:0] S_R    = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              rerr_q, rerr_d;   // sticky RLAST protocol violation
    logic              run_q;            // low while in reset, high from the first clock after release

    logic              in_w, in_r, last_beat, w_hs, rlast_bad, cross_4k;

    // -------------------------------------------------------------------------
    // 4 KiB boundary check on the incoming command
    // -------------------------------------------------------------------------
`ifdef AXI_4K_CHECK_EN
    localparam int BEAT_BYTES = DATA_W / 8;
    logic [16:0] end_off;

    // End offset within the 4 KiB page. 17 bits covers 4095 + 256*128.
    assign end_off  = 17'(cmd_addr[11:0]) + (17'(cmd_len) + 17'd1) * 17'(BEAT_BYTES);
    assign cross_4k = end_off > 17'd4096;
`else
    assign cross_4k = 1'b0;
`endif

    assign in_w      = (state_q == S_W);
    assign in_r      = (state_q == S_R);
    assign last_beat = (cnt_q == len_q);
    assign w_hs      = in_w && wr_valid && WREADY;
    assign rlast_bad = (RLAST != last_beat);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of the block, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        rerr_d  = rerr_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    // The direction is captured by the choice of next state,
                    // so it needs no register of its own.
                    addr_d = cmd_addr;
                    len_d  = cmd_len;
                    cnt_d  = 8'd0;
                    rerr_d = 1'b0;
                    if (cross_4k) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d = cmd_write ? S_AW : S_AR;
                    end
                end
            end

            S_AW: if (AWREADY) state_d = S_W;

            S_W: begin
                if (w_hs) begin
                    if (last_beat) begin
                        state_d = S_B;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            S_B: begin
                if (BVALID) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end

            S_AR: if (ARREADY) state_d = S_R;

            S_R: begin
                if (RVALID) begin
                    // The burst length comes from the command, not from RLAST.
                    // A misplaced RLAST only flags the command as failed.
                    if (last_beat) begin
                        state_d = S_IDLE;
                        cnt_d   = 8'd0;
                        done_d  = 1'b1;
                        err_d   = rerr_q | rlast_bad;
                        rerr_d  = 1'b0;
                    end else begin
                        cnt_d  = cnt_q + 8'd1;
                        rerr_d = rerr_q | rlast_bad;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so that all
    // registers update together from the values sampled at the edge.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rerr_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rerr_q  <= rerr_d;
            run_q   <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: all decoded from state so reset clears them immediately.
    // -------------------------------------------------------------------------
    // The next command is held off while done is high, so it can only be
    // accepted on the cycle after the completion pulse.
    assign cmd_ready = run_q && (state_q == S_IDLE) && !done_q;

    assign AWVALID   = (state_q == S_AW);
    assign AWADDR    = AWVALID ? addr_q : '0;
    assign AWLEN     = AWVALID ? len_q  : '0;

    assign ARVALID   = (state_q == S_AR);
    assign ARADDR    = ARVALID ? addr_q : '0;
    assign ARLEN     = ARVALID ? len_q  : '0;

    // The write source is expected to hold wr_valid/wr_data until consumed.
    // Passing them through keeps WVALID/WDATA stable until the handshake.
    assign WVALID    = in_w && wr_valid;
    assign WDATA     = in_w ? wr_data : '0;
    assign WLAST     = in_w && last_beat;
    assign wr_ready  = in_w && WREADY;

    assign BREADY    = (state_q == S_B);

    assign RREADY    = in_r;
    assign rd_valid  = in_r && RVALID;
    assign rd_data   = in_r ? RDATA : '0;

    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_axi4_burst_master.sv
`timescale 1ns/1ps
module tb_axi4_burst_master;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

`ifdef AXI_4K_CHECK_EN
    localparam bit K4 = 1'b1;
`else
    localparam bit K4 = 1'b0;
`endif

    logic              ACLK = 1'b0;
    logic              ARESETn = 1'b0;
    logic              cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [7:0]        cmd_len = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_valid = 1'b0, wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid, done, err;
    logic [ADDR_W-1:0] AWADDR, ARADDR;
    logic [7:0]        AWLEN, ARLEN;
    logic              AWVALID, AWREADY = 1'b0;
    logic [DATA_W-1:0] WDATA;
    logic              WLAST, WVALID, WREADY = 1'b0;
    logic              BVALID = 1'b0, BREADY;
    logic              ARVALID, ARREADY = 1'b0;
    logic [DATA_W-1:0] RDATA = '0;
    logic              RLAST = 1'b0, RVALID = 1'b0, RREADY;

    axi4_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // One command and the behaviour expected of it.
    // mode: 0 = no stalls, 1 = random stalls, 2 = scripted gaps/stall
    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [31:0] base;      // beat i carries base+i
        int          aw_delay;  // AxREADY low cycles before the handshake
        int          bad_beat;  // read beat index whose RLAST is inverted, -1 none
        int          mode;
        bit          exp_err;
        bit          exp_reject;
    } vec_t;

    // Reference rules
    function automatic bit model_reject(input logic [31:0] addr, input logic [7:0] len);
        int off;
        off = int'(addr % 32'd4096) + (int'(len) + 1) * (DATA_W / 8);
        return K4 && (off > 4096);
    endfunction

    function automatic bit model_err(input vec_t v);
        return !v.write && (v.bad_beat >= 0) && (v.bad_beat <= int'(v.len));
    endfunction

    task automatic run_cmd(input vec_t v);
        int  beat, guard, wcyc, d, dly;
        bit  wv, wrdy, rv, pend;

        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        check("cmd_ready_idle", cmd_ready, 1);

        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        tick();
        cmd_valid = 1'b0;

        if (v.exp_reject) begin
            check("rej_awvalid", AWVALID, 0);
            check("rej_arvalid", ARVALID, 0);
            check("rej_done", done, 1);
            check("rej_err", err, 1);
            check("rej_cmd_ready", cmd_ready, 0);
            tick();
            check("rej_done_clear", done, 0);
            check("rej_no_aw", AWVALID, 0);
            return;
        end

        if (v.write) begin
            // Address phase; the write source is already offering a beat,
            // which must not be consumed before the W phase.
            for (d = 0; d <= v.aw_delay; d++) begin
                AWREADY  = (d == v.aw_delay);
                wr_valid = 1'b1;
                wr_data  = v.base;
                WREADY   = 1'b1;
                #1;
                check("awvalid", AWVALID, 1);
                check("awaddr", AWADDR, v.addr);
                check("awlen", AWLEN, v.len);
                check("wr_ready_in_aw", wr_ready, 0);
                check("wvalid_in_aw", WVALID, 0);
                tick();
            end
            AWREADY = 1'b0;

            beat = 0; guard = 0; wcyc = 0; pend = 1'b0;
            while (beat <= int'(v.len) && guard < 4000) begin
                case (v.mode)
                    0: begin wv = 1'b1; wrdy = 1'b1; end
                    1: begin
                        wv   = pend || ($urandom_range(0, 3) != 0);
                        wrdy = ($urandom_range(0, 2) != 0);
                    end
                    default: begin
                        wv   = pend || !(wcyc == 1 || wcyc == 2);
                        wrdy = !(wcyc >= 5 && wcyc <= 7);
                    end
                endcase
                wr_valid = wv;
                wr_data  = v.base + beat;
                WREADY   = wrdy;
                #1;
                check("wvalid", WVALID, wv);
                check("wr_ready", wr_ready, wrdy);
                check("wlast", WLAST, beat == int'(v.len));
                if (wv) check("wdata", WDATA, v.base + beat);
                pend = wv && !wrdy;
                if (wv && wrdy) beat++;
                tick();
                wcyc++;
                guard++;
            end
            if (guard >= 4000) check("w_timeout", 0, 1);
            wr_valid = 1'b0;
            WREADY   = 1'b0;

            dly = (v.mode == 0) ? 0 : int'($urandom_range(0, 3));
            for (d = 0; d <= dly; d++) begin
                BVALID = (d == dly);
                #1;
                check("bready", BREADY, 1);
                check("wvalid_in_b", WVALID, 0);
                check("done_early", done, 0);
                tick();
            end
            BVALID = 1'b0;
            check("w_done", done, 1);
            check("w_err", err, 0);
            check("cmd_ready_during_done", cmd_ready, 0);
            tick();
            check("w_done_clear", done, 0);
        end else begin
            for (d = 0; d <= v.aw_delay; d++) begin
                ARREADY = (d == v.aw_delay);
                #1;
                check("arvalid", ARVALID, 1);
                check("araddr", ARADDR, v.addr);
                check("arlen", ARLEN, v.len);
                check("rready_in_ar", RREADY, 0);
                tick();
            end
            ARREADY = 1'b0;

            beat = 0; guard = 0;
            while (beat <= int'(v.len) && guard < 4000) begin
                rv     = (v.mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                RVALID = rv;
                RDATA  = rv ? (v.base + beat) : $urandom;
                RLAST  = rv && ((beat == int'(v.len)) ^ (beat == v.bad_beat));
                #1;
                check("rready", RREADY, 1);
                check("rd_valid", rd_valid, rv);
                if (rv) check("rd_data", rd_data, v.base + beat);
                check("r_done_early", done, 0);
                if (rv) beat++;
                tick();
                guard++;
            end
            if (guard >= 4000) check("r_timeout", 0, 1);
            RVALID = 1'b0;
            RLAST  = 1'b0;
            check("r_rready_after", RREADY, 0);
            check("r_done", done, 1);
            check("r_err", err, v.exp_err);
            tick();
            check("r_done_clear", done, 0);
            check("r_err_clear", err, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    vec_t tbl[11];
    vec_t rv_cmd;

    initial begin
        tbl[0]  = '{write:1'b1, addr:32'h0,    len:8'd3,   base:32'h100,  aw_delay:2, bad_beat:-1, mode:0, exp_err:1'b0, exp_reject:1'b0};
        tbl[1]  = '{write:1'b0, addr:32'h40,   len:8'd3,   base:32'h200,  aw_delay:1, bad_beat:-1, mode:0, exp_err:1'b0, exp_reject:1'b0};
        tbl[2]  = '{write:1'b1, addr:32'h80,   len:8'd7,   base:32'h300,  aw_delay:0, bad_beat:-1, mode:2, exp_err:1'b0, exp_reject:1'b0};
        tbl[3]  = '{write:1'b0, addr:32'h100,  len:8'd3,   base:32'h500,  aw_delay:0, bad_beat:1,  mode:0, exp_err:1'b1, exp_reject:1'b0};
        tbl[4]  = '{write:1'b1, addr:32'hFF8,  len:8'd3,   base:32'h400,  aw_delay:0, bad_beat:-1, mode:0, exp_err:1'b0, exp_reject:K4};
        tbl[5]  = '{write:1'b0, addr:32'h0,    len:8'd0,   base:32'h600,  aw_delay:0, bad_beat:-1, mode:0, exp_err:1'b0, exp_reject:1'b0};
        tbl[6]  = '{write:1'b0, addr:32'h10,   len:8'd0,   base:32'h700,  aw_delay:0, bad_beat:0,  mode:0, exp_err:1'b1, exp_reject:1'b0};
        tbl[7]  = '{write:1'b1, addr:32'h0,    len:8'd255, base:32'h1000, aw_delay:0, bad_beat:-1, mode:0, exp_err:1'b0, exp_reject:1'b0};
        tbl[8]  = '{write:1'b0, addr:32'h2000, len:8'd255, base:32'h2000, aw_delay:3, bad_beat:254, mode:1, exp_err:1'b1, exp_reject:1'b0};
        tbl[9]  = '{write:1'b1, addr:32'hFFC,  len:8'd0,   base:32'h800,  aw_delay:1, bad_beat:-1, mode:1, exp_err:1'b0, exp_reject:1'b0};
        tbl[10] = '{write:1'b0, addr:32'hFFC,  len:8'd1,   base:32'h900,  aw_delay:0, bad_beat:-1, mode:0, exp_err:1'b0, exp_reject:K4};

        // Reset state
        #12;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_awvalid", AWVALID, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        ARESETn = 1'b1;
        tick();
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_arvalid", ARVALID, 0);

        for (int i = 0; i < 11; i++) run_cmd(tbl[i]);

        // Randomized commands checked against the reference rules
        for (int i = 0; i < 24; i++) begin
            rv_cmd.write    = ($urandom_range(0, 1) == 1);
            rv_cmd.addr     = $urandom & 32'h0000_FFFC;
            rv_cmd.len      = 8'($urandom_range(0, 15));
            rv_cmd.base     = $urandom;
            rv_cmd.aw_delay = int'($urandom_range(0, 3));
            rv_cmd.bad_beat = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1;
            rv_cmd.mode     = 1;
            rv_cmd.exp_err    = model_err(rv_cmd);
            rv_cmd.exp_reject = model_reject(rv_cmd.addr, rv_cmd.len);
            run_cmd(rv_cmd);
        end

        // Reset in the middle of beat 2 of a len-7 write
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h3000; cmd_len = 8'd7;
        tick();
        cmd_valid = 1'b0;
        AWREADY = 1'b1;
        tick();
        AWREADY  = 1'b0;
        wr_valid = 1'b1; wr_data = 32'hA0; WREADY = 1'b1;
        tick();
        wr_data = 32'hA1;
        #1;
        check("pre_rst_wvalid", WVALID, 1);
        #1;
        ARESETn = 1'b0;
        #1;
        check("arst_wvalid", WVALID, 0);
        check("arst_wr_ready", wr_ready, 0);
        check("arst_wdata", WDATA, 0);
        check("arst_wlast", WLAST, 0);
        check("arst_awvalid", AWVALID, 0);
        check("arst_awaddr", AWADDR, 0);
        check("arst_awlen", AWLEN, 0);
        check("arst_bready", BREADY, 0);
        check("arst_arvalid", ARVALID, 0);
        check("arst_rready", RREADY, 0);
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        check("arst_cmd_ready", cmd_ready, 0);
        tick();
        tick();
        #2;
        ARESETn = 1'b1;
        tick();
        check("rel_cmd_ready", cmd_ready, 1);
        check("rel_no_resume_w", WVALID, 0);
        check("rel_no_resume_aw", AWVALID, 0);
        wr_valid = 1'b0; WREADY = 1'b0;

        run_cmd(tbl[0]);
        run_cmd(tbl[3]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
